// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: SRAM-like req/addr_ok/data_ok slave to a single-beat AXI read master.
// Optional macro INST_BRIDGE_CANCEL_EN adds inst_cancel and drops responses to flushed fetches.
module inst_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  ARID_VAL        = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  // fetch-side SRAM-like interface
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
`ifdef INST_BRIDGE_CANCEL_EN
  input  logic        inst_cancel,
`endif
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ArIdle,
    ArSend
  } ar_state_e;

  ar_state_e   state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q, rdata_d;
  logic        r_hs;
  logic        r_beat;
  logic        suppress;

  // Single ID and in-order AXI return: no ID checking, status or burst tracking needed.
  logic unused_r;
  assign unused_r = ^{rid, rresp, rlast};

  assign r_hs   = rvalid && rready;
  // A beat with nothing outstanding is a slave protocol error and is dropped.
  assign r_beat = r_hs && (cnt_q != 3'd0);

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    inst_addr_ok = 1'b0;
    unique case (state_q)
      ArIdle: begin
        if (!reset && inst_req && (cnt_q < MaxCnt)) begin
          inst_addr_ok = 1'b1;
          araddr_d     = inst_addr;
          state_d      = ArSend;
        end
      end
      ArSend: begin
        if (arready) begin
          state_d = ArIdle;
        end
      end
      default: state_d = ArIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inst_addr_ok, r_beat})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef INST_BRIDGE_CANCEL_EN
  logic [2:0] discard_q, discard_d;

  assign suppress = (discard_q != 3'd0);

  // A flush condemns everything still outstanding once this edge settles, including
  // a fetch accepted in the same cycle; an already-issued AR is left to complete.
  always_comb begin
    discard_d = discard_q;
    if (inst_cancel) begin
      discard_d = cnt_d;
    end else if (r_beat && suppress) begin
      discard_d = discard_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      discard_q <= 3'd0;
    end else begin
      discard_q <= discard_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    data_ok_d = r_beat && !suppress;
    rdata_d   = data_ok_d ? rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ArIdle;
      araddr_q  <= 32'd0;
      cnt_q     <= 3'd0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign inst_data_ok = data_ok_q;
  assign inst_rdata   = rdata_q;

  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = (state_q == ArSend) && !reset;
  assign rready  = !reset;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboarded bench for inst_axi_rd_bridge: a fetch/AXI-slave driver feeds a reference model,
// and an independent monitor checks every inst_data_ok against the expected-data queue.
module tb_inst_axi_rd_bridge;

  localparam int unsigned MAX    = 2;
  localparam logic [3:0]  ARID   = 4'd5;
  localparam int          PERIOD = 10;
`ifdef INST_BRIDGE_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
`ifdef INST_BRIDGE_CANCEL_EN
  logic        inst_cancel = 1'b0;
`endif
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  always #(PERIOD / 2) clk = ~clk;

  inst_axi_rd_bridge #(
    .MAX_OUTSTANDING(MAX),
    .ARID_VAL       (ARID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
`ifdef INST_BRIDGE_CANCEL_EN
    .inst_cancel (inst_cancel),
`endif
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .arburst     (arburst),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready)
  );

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } fetch_t;

  fetch_t      pend[$];     // accepted fetches not yet answered, in order
  logic [31:0] slave_q[$];  // addresses the slave has accepted on AR
  logic [31:0] exp_q[$];    // data the monitor must see on inst_data_ok
  bit          ar_busy = 1'b0;
  logic [31:0] ar_addr = 32'd0;
  time         t_acc = 0;
  time         t_dok = 0;
  int          n_tests = 0;
  int          n_fails = 0;

  // Slave memory contents: 0xbfc00000 reads back as 0x3c1a0000.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h83da_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the model to the edge.
  task automatic step(input bit req, input logic [31:0] addr, input bit ardy, input bit rv,
                      input bit cancel, input bit rst);
    bit     exp_ok;
    bit     r_hs;
    fetch_t f;
    @(negedge clk);
    #2;
    reset     = rst;
    inst_req  = req;
    inst_addr = addr;
    arready   = ardy;
`ifdef INST_BRIDGE_CANCEL_EN
    inst_cancel = cancel;
`endif
    r_hs   = rv && !rst && (slave_q.size() > 0);
    rvalid = r_hs;
    rdata  = r_hs ? mem(slave_q[0]) : $urandom;
    rresp  = 2'($urandom);
    rid    = 4'($urandom);
    #1;
    exp_ok = req && !rst && !ar_busy && (pend.size() < MAX);
    check("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, exp_ok});
    check("rready", {31'd0, rready}, {31'd0, !rst});
    check("arvalid", {31'd0, arvalid}, {31'd0, ar_busy && !rst});
    if (ar_busy && !rst) check("araddr_stable", araddr, ar_addr);
    if (rst) begin
      pend.delete();
      slave_q.delete();
      ar_busy = 1'b0;
      return;
    end
    if (r_hs) begin
      if (!pend[0].drop) exp_q.push_back(mem(pend[0].addr));
      void'(pend.pop_front());
      void'(slave_q.pop_front());
    end
    if (ar_busy && ardy) begin
      slave_q.push_back(ar_addr);
      ar_busy = 1'b0;
    end
    if (exp_ok) begin
      f.addr = addr;
      f.drop = 1'b0;
      pend.push_back(f);
      ar_busy = 1'b1;
      ar_addr = addr;
      t_acc   = $time;
    end
    if (cancel && CANCEL_EN) begin
      foreach (pend[i]) pend[i].drop = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((pend.size() > 0 || ar_busy) && n < 100) begin
      step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      n++;
    end
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("drain_outstanding", 32'(pend.size()) + {31'd0, ar_busy}, 32'd0);
    check("drain_expected", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: registered outputs are sampled on the falling edge.
  initial begin
    logic [31:0] last;
    logic [31:0] e;
    last = 32'd0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        last = 32'd0;
        check("reset_data_ok", {31'd0, inst_data_ok}, 32'd0);
        check("reset_rdata", inst_rdata, 32'd0);
      end else if (inst_data_ok) begin
        t_dok = $time;
        check("data_ok_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("inst_rdata", inst_rdata, e);
          last = e;
        end
      end else begin
        check("rdata_hold", inst_rdata, last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arid", {28'd0, arid}, {28'd0, ARID});
    check("arlen", {24'd0, arlen}, 32'd0);
    check("arsize", {29'd0, arsize}, 32'd2);
    check("arburst", {30'd0, arburst}, 32'd1);

    // Single fetch at minimum latency.
    t_dok = 0;
    step(1'b1, 32'hbfc0_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fetch_latency", 32'((t_dok - t_acc + 3) / PERIOD), 32'd3);
    check("first_rdata", inst_rdata, 32'h3c1a_0000);

    // arready held low: address must hold and no further accept.
    step(1'b1, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_2000 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Outstanding limit with rvalid withheld, then overlapping accept and R beat.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h1000_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h2000_0000 + 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

`ifdef INST_BRIDGE_CANCEL_EN
    // Flush two outstanding fetches; only the following fetch may return data.
    step(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hbfc0_0380, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    check("cancel_rdata", inst_rdata, mem(32'hbfc0_0380));
`endif

    // Reset while the AR is still pending.
    step(1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_arvalid", {31'd0, arvalid}, 32'd0);
    check("post_reset_rdata", inst_rdata, 32'd0);
    // A cleared counter must admit MAX new fetches.
    for (int i = 0; i < 2 * MAX + 2; i++) step(1'b1, 32'h0000_4000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomized traffic, including flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3fff_ffff), 2'b00},
           $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
# inst_axi_rd_bridge

Instruction-side read bridge sitting directly upstream of the IF stage: it is the slave for the fetch stage's SRAM-like request/addr_ok/data_ok interface and the master on an AXI read-address/read-data channel pair. It converts each accepted fetch into a single-beat 32-bit AXI read and returns the data in request order. It tracks outstanding reads and, when configured, silently drops responses to fetches the pipeline has flushed.

## Interface
Parameters:
- MAX_OUTSTANDING, 2, maximum fetches accepted but not yet answered (1..7)
- ARID_VAL, 4'd0, constant AXI ID driven on arid

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- inst_req  input  1  IF requests a fetch this cycle
- inst_addr  input  32  physical fetch address, valid with inst_req
- inst_addr_ok  output  1  request accepted this cycle
- inst_data_ok  output  1  one-cycle pulse, inst_rdata valid
- inst_rdata  output  32  returned instruction, held until next inst_data_ok
- inst_cancel  input  1  IF flush; all fetches outstanding at this edge are discarded (only with INST_BRIDGE_CANCEL_EN)
- arid  output  4  = ARID_VAL
- araddr  output  32  read address
- arlen  output  8  constant 0
- arsize  output  3  constant 3'b010
- arburst  output  2  constant 2'b01
- arvalid  output  1  address valid
- arready  input  1  address accepted
- rid  input  4  ignored
- rdata  input  32  read data
- rresp  input  2  ignored; data forwarded regardless
- rlast  input  1  expected 1 on every beat
- rvalid  input  1  read data valid
- rready  output  1  read data ready

## Operation
- AR FSM, two states: AR_IDLE, AR_SEND.
- inst_addr_ok = !reset && state==AR_IDLE && inst_req && cnt < MAX_OUTSTANDING (combinational; IF uses it same cycle).
- On inst_addr_ok: latch inst_addr into araddr, cnt+1, go AR_SEND.
- AR_SEND: arvalid=1, araddr stable; on arready go AR_IDLE. No new request accepted in AR_SEND.
- cnt (3 bits): +1 on inst_addr_ok, -1 on R handshake (rvalid && rready); both same cycle → unchanged. Never exceeds MAX_OUTSTANDING, never underflows (R beat with cnt==0 is a protocol error, ignored).
- rready = !reset; bridge always sinks data.
- On R handshake: register rdata into inst_rdata, pulse inst_data_ok next cycle (unless discarded, see Configuration).
- Responses returned in AXI arrival order; single ID guarantees request order.
- rresp non-OKAY: data still delivered, no error signalled.

## Timing
- Reset values: inst_addr_ok 0, inst_data_ok 0, inst_rdata 0, arvalid 0, araddr 0, rready 0, state AR_IDLE, cnt 0, discard 0.
- Reset mid-operation: all state cleared in one cycle; AXI slave is reset concurrently, so no stale beats are expected.
- Cycle 0 addr_ok; cycle 1 arvalid=1 (earliest arready); cycle 2 earliest rvalid; cycle 3 earliest inst_data_ok. Minimum fetch latency 3 cycles.
- Back-to-back requests: one accept every 2 cycles when arready is immediate.
- inst_rdata changes only on the cycle inst_data_ok rises; stable otherwise, so IF may sample it any later cycle.

## Configuration
- INST_BRIDGE_CANCEL_EN defined: inst_cancel port exists. On inst_cancel, discard ← number of fetches outstanding after this edge's updates (cnt_next, including a request accepted the same cycle). Each subsequent R handshake with discard>0 decrements discard and suppresses inst_data_ok; inst_rdata is not updated. Cancel while discard>0 reloads discard with cnt_next. AR in flight still completes.
- Not defined: no inst_cancel port, discard logic absent; every response produces inst_data_ok.

## Test plan
- Single fetch, arready/rvalid immediate: req addr 0xbfc00000 cycle 0 → araddr 0xbfc00000 arvalid cycle 1, rdata 0x3c1a0000 cycle 2 → inst_data_ok=1, inst_rdata=0x3c1a0000 cycle 3.
- arready held low 5 cycles: arvalid and araddr stable 5 cycles, inst_addr_ok stays 0 despite inst_req.
- MAX_OUTSTANDING=2, rvalid withheld: two accepts, third inst_req gets no addr_ok until first R beat; responses 0x11111111, 0x22222222 delivered in order.
- Simultaneous accept and R beat: cnt unchanged, data_ok pulse next cycle, third request accepted.
- With INST_BRIDGE_CANCEL_EN: two outstanding, inst_cancel pulsed, then new fetch 0xbfc00380 → first two responses suppressed, only third yields inst_data_ok with its data; inst_rdata unchanged until then.
- Reset asserted with one read outstanding in AR_SEND → next cycle arvalid 0, cnt 0, inst_data_ok 0, inst_rdata 0.
